// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-addressed load/store front end for a 32-bit word DMem
module load_store_unit #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     ReqValid,
    output logic                     ReqReady,
    input  logic                     ReqWrite,
    input  logic [1:0]               ReqSize,
    input  logic                     ReqSigned,
    input  logic [ADDRESS_WIDTH+1:0] ReqAddr,
    input  logic [DATA_WIDTH-1:0]    ReqWData,
    output logic                     RespValid,
    output logic [DATA_WIDTH-1:0]    RespData,
    output logic                     RespError,
    output logic [ADDRESS_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0]    MemWriteData,
    output logic                     MemWrite,
    input  logic [DATA_WIDTH-1:0]    MemData
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

    state_t                   state_q;
    logic                     size_signed_q;
    logic [1:0]               size_q;
    logic [1:0]               lane_q;
    logic [31:0]              wdata_q;
    logic                     resp_valid_q;
    logic                     resp_error_q;
    logic [31:0]              resp_data_q;
    logic [ADDRESS_WIDTH-1:0] mem_address_q;
    logic [31:0]              mem_wdata_q;
    logic                     mem_write_q;

    logic                     req_err;
    logic [4:0]               shamt;
    logic [31:0]              shifted;
    logic [31:0]              lane_mask;
    logic [31:0]              load_d;
    logic [31:0]              merge_d;

    assign ReqReady     = (state_q == IDLE) && Reset_n;
    assign RespValid    = resp_valid_q;
    assign RespError    = resp_error_q;
    assign RespData     = resp_data_q;
    assign MemAddress   = mem_address_q;
    assign MemWriteData = mem_wdata_q;
    assign MemWrite     = mem_write_q;

    assign req_err = (ReqSize == 2'b11)
                  || ((ReqSize == 2'b01) && ReqAddr[0])
                  || ((ReqSize == 2'b10) && (ReqAddr[1:0] != 2'b00));

    // Halfwords are always 2-aligned here, so the byte shift also selects the half lane.
    assign shamt     = {lane_q, 3'b000};
    assign shifted   = MemData >> shamt;
    assign lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
    assign merge_d   = (MemData & ~lane_mask) | ((wdata_q << shamt) & lane_mask);

    always_comb begin
        load_d = MemData;
        case (size_q)
            2'b00:   load_d = {{24{size_signed_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_d = {{16{size_signed_q & shifted[15]}}, shifted[15:0]};
            default: load_d = MemData;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            size_signed_q <= 1'b0;
            size_q        <= 2'b00;
            lane_q        <= 2'b00;
            wdata_q       <= 32'h0;
            resp_valid_q  <= 1'b0;
            resp_error_q  <= 1'b0;
            resp_data_q   <= 32'h0;
            mem_address_q <= '0;
            mem_wdata_q   <= 32'h0;
            mem_write_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ReqValid) begin
                        size_signed_q <= ReqSigned;
                        size_q        <= ReqSize;
                        lane_q        <= ReqAddr[1:0];
                        wdata_q       <= ReqWData;
                        mem_address_q <= ReqAddr[ADDRESS_WIDTH+1:2];
                        resp_data_q   <= 32'h0;
                        resp_error_q  <= 1'b0;
                        if (req_err) begin
                            resp_error_q <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else if (!ReqWrite) begin
                            state_q <= LOAD;
                        end else if (ReqSize == 2'b10) begin
                            mem_wdata_q <= ReqWData;
                            mem_write_q <= 1'b1;
                            state_q     <= WRITE;
                        end else begin
                            state_q <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    resp_data_q  <= load_d;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RMW_RD: begin
                    mem_wdata_q <= merge_d;
                    mem_write_q <= 1'b1;
                    state_q     <= WRITE;
                end
                WRITE: begin
                    mem_write_q  <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_error_q <= 1'b0;
                    mem_write_q  <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a DMem model
module tb_load_store_unit;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic [17:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        RespValid;
    logic [31:0] RespData;
    logic        RespError;
    logic [15:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemWrite;
    logic [31:0] MemData;

    logic [31:0] mem [0:65535];

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   mw_cnt   = 0;

    load_store_unit #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqWrite(ReqWrite), .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddr(ReqAddr),
        .ReqWData(ReqWData), .RespValid(RespValid), .RespData(RespData), .RespError(RespError),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemWrite(MemWrite),
        .MemData(MemData)
    );

    always #5 Clk = ~Clk;

    assign MemData = mem[MemAddress];

    always @(negedge Clk) begin
        if (MemWrite) mem[MemAddress] <= MemWriteData;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each response and checks data, error and latency.
    always @(negedge Clk) begin
        exp_t e;
        cyc++;
        if (MemWrite) mw_cnt++;
        if (RespValid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_data", RespData, e.data);
                chk("resp_error", {31'b0, RespError}, {31'b0, e.err});
                chk("resp_latency", cyc - e.acc, e.lat);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic submit(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [17:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_data, input logic exp_err,
                          input int exp_lat, input bit push);
        exp_t e;
        int   n;
        ReqWrite  = w;
        ReqSize   = sz;
        ReqSigned = sg;
        ReqAddr   = addr;
        ReqWData  = wd;
        ReqValid  = 1'b1;
        n = 0;
        while (!ReqReady && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (!ReqReady) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge Clk);
        if (push) begin
            e.data = exp_data;
            e.err  = exp_err;
            e.lat  = exp_lat;
            e.acc  = cyc;
            sb.push_back(e);
        end
        @(negedge Clk);
        chk("ready_low_busy", {31'b0, ReqReady}, 32'd0);
        ReqValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        @(negedge Clk);
    endtask

    initial begin
        int snap;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        Reset_n = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00;
        ReqSigned = 1'b0; ReqAddr = '0; ReqWData = 32'h0;
        repeat (3) @(negedge Clk);
        chk("rst_resp_valid", {31'b0, RespValid}, 32'd0);
        chk("rst_mem_write", {31'b0, MemWrite}, 32'd0);
        chk("rst_mem_addr", {16'b0, MemAddress}, 32'd0);
        chk("rst_resp_data", RespData, 32'd0);
        chk("rst_mem_wdata", MemWriteData, 32'd0);
        chk("rst_ready", {31'b0, ReqReady}, 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("ready_after_rst", {31'b0, ReqReady}, 32'd1);

        // 1: word store / load
        submit(1, 2'b10, 0, 18'h0010, 32'hDEADBEEF, 32'h0, 0, 2, 1);
        chk("t1_mem_addr", {16'b0, MemAddress}, 32'h0004);
        drain();
        submit(0, 2'b10, 0, 18'h0010, 32'h0, 32'hDEADBEEF, 0, 2, 1);
        chk("t1_load_addr", {16'b0, MemAddress}, 32'h0004);
        drain();

        // 2: byte RMW and byte loads
        submit(1, 2'b10, 0, 18'h0010, 32'h11223344, 32'h0, 0, 2, 1);
        submit(1, 2'b00, 0, 18'h0013, 32'h000000A5, 32'h0, 0, 3, 1);
        drain();
        chk("t2_mem_word", mem[4], 32'hA5223344);
        submit(0, 2'b00, 1, 18'h0013, 32'h0, 32'hFFFFFFA5, 0, 2, 1);
        submit(0, 2'b00, 0, 18'h0013, 32'h0, 32'h000000A5, 0, 2, 1);
        submit(0, 2'b10, 1, 18'h0010, 32'h0, 32'hA5223344, 0, 2, 1);
        drain();

        // 3: half RMW and half loads
        submit(1, 2'b10, 0, 18'h0020, 32'h0, 32'h0, 0, 2, 1);
        submit(1, 2'b01, 0, 18'h0022, 32'h00008001, 32'h0, 0, 3, 1);
        drain();
        chk("t3_mem_word", mem[8], 32'h80010000);
        submit(0, 2'b01, 1, 18'h0022, 32'h0, 32'hFFFF8001, 0, 2, 1);
        submit(0, 2'b01, 0, 18'h0022, 32'h0, 32'h00008001, 0, 2, 1);
        drain();

        // 4: error cases
        snap = mw_cnt;
        submit(1, 2'b10, 0, 18'h0011, 32'h12345678, 32'h0, 1, 1, 1);
        submit(0, 2'b01, 0, 18'h0021, 32'h0, 32'h0, 1, 1, 1);
        submit(0, 2'b11, 0, 18'h0000, 32'h0, 32'h0, 1, 1, 1);
        drain();
        chk("t4_no_mem_write", mw_cnt - snap, 32'd0);
        chk("t4_mem_untouched", mem[4], 32'hA5223344);

        // 5: reset while in RMW_RD
        submit(1, 2'b10, 0, 18'h0030, 32'hCAFEF00D, 32'h0, 0, 2, 1);
        drain();
        snap = mw_cnt;
        submit(1, 2'b00, 0, 18'h0030, 32'h000000EE, 32'h0, 0, 3, 0);
        Reset_n = 1'b0;
        @(negedge Clk);
        chk("t5_mem_write_low", {31'b0, MemWrite}, 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("t5_ready_after", {31'b0, ReqReady}, 32'd1);
        repeat (3) @(negedge Clk);
        chk("t5_no_mem_write", mw_cnt - snap, 32'd0);
        chk("t5_mem_word", mem[12], 32'hCAFEF00D);

        // 6: back-to-back requests with ReqValid held
        submit(1, 2'b10, 0, 18'h0040, 32'h01020304, 32'h0, 0, 2, 1);
        drain();
        submit(0, 2'b00, 0, 18'h0040, 32'h0, 32'h00000004, 0, 2, 1);
        submit(1, 2'b00, 0, 18'h0041, 32'hFFFFFF5A, 32'h0, 0, 3, 1);
        submit(0, 2'b10, 0, 18'h0040, 32'h0, 32'h01025A04, 0, 2, 1);
        drain();
        chk("t6_mem_word", mem[16], 32'h01025A04);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
